seq_alu: RTL and testbench

Registered execute-stage ALU that consumes the 3-bit ALU control code and the two operand buses and produces the result. AND/OR/ADD/SUB complete in one cycle; MUL runs as an iterative shift-add over WIDTH cycles and stalls the pipeline through `busy_o` until done. It sits directly downstream of the ALU control decoder and upstream of the EX/MEM register.

---
 rtl/alu_pkg.sv | 16 +
 rtl/seq_alu_if.sv | 24 ++
 rtl/shift_add_mul.sv | 46 ++++
 rtl/seq_alu.sv | 91 +++++++++
 tb/tb_seq_alu.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and sequencer state encoding; the ALU control
// decoder drives the same codes, so they live here rather than in the ALU.
package alu_pkg;

  localparam logic [2:0] ALUCTRL_AND = 3'b000;
  localparam logic [2:0] ALUCTRL_OR  = 3'b001;
  localparam logic [2:0] ALUCTRL_ADD = 3'b010;
  localparam logic [2:0] ALUCTRL_SUB = 3'b011;
  localparam logic [2:0] ALUCTRL_MUL = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the ALU control stage and the execute ALU.
// The master drives the request and operands; the slave returns the result flags.
interface seq_alu_if #(parameter int WIDTH = 32);

  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             done_o;
  logic             busy_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, zero_o, done_o, busy_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, zero_o, done_o, busy_o
  );

endinterface

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per step, WIDTH steps.
// product is the accumulator including the current step; last flags the final step.
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  // Exposing the post-step sum lets the top capture the result on the last edge.
  assign product = acc + (multiplier[0] ? multiplicand : '0);
  assign last    = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      count        <= '0;
    end else if (load) begin
      multiplicand <= a;
      multiplier   <= b;
      acc          <= '0;
      count        <= '0;
    end else if (step) begin
      acc          <= product;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      count        <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: AND/OR/ADD/SUB in one cycle, MUL over WIDTH cycles.
// busy_o holds the pipeline during MUL; requests arriving while busy are dropped.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk_i,
  input  logic    rst_n_i,
  seq_alu_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             done_q;
  logic             busy_q;
  logic [WIDTH-1:0] sc_result;
  logic [WIDTH-1:0] mul_product;
  logic             mul_last;
  logic             mul_load;
  logic             mul_step;

  assign mul_load = (state == ST_IDLE) && bus.start_i && (bus.ALUCtrl_i == ALUCTRL_MUL);
  assign mul_step = (state == ST_MUL);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.data1_i),
    .b       (bus.data2_i),
    .last    (mul_last),
    .product (mul_product)
  );

  // Reserved codes fall through to zero so the pipeline still sees a completion.
  always_comb begin
    sc_result = '0;
    case (bus.ALUCtrl_i)
      ALUCTRL_AND: sc_result = bus.data1_i & bus.data2_i;
      ALUCTRL_OR:  sc_result = bus.data1_i | bus.data2_i;
      ALUCTRL_ADD: sc_result = bus.data1_i + bus.data2_i;
      ALUCTRL_SUB: sc_result = bus.data1_i - bus.data2_i;
      default:     sc_result = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= ST_IDLE;
      data_q <= '0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (bus.ALUCtrl_i == ALUCTRL_MUL) begin
              state  <= ST_MUL;
              busy_q <= 1'b1;
            end else begin
              data_q <= sc_result;
              zero_q <= (sc_result == '0);
              done_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            state  <= ST_IDLE;
            data_q <= mul_product;
            zero_q <= (mul_product == '0);
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_o = data_q;
  assign bus.zero_o = zero_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu with hand-computed expected results.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request for exactly one edge; returns 1 time unit after that edge.
  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = c;
    bus.data1_i   = a;
    bus.data2_i   = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.data_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=%h", bus.data_o, 32'h0); end
    checks++;
    if (bus.zero_o !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", bus.zero_o); end
    checks++;
    if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_logic_arith();
    logic [2:0]  ops [5] = '{ALUCTRL_AND, ALUCTRL_OR, ALUCTRL_ADD, ALUCTRL_SUB, ALUCTRL_SUB};
    logic [31:0] va  [5] = '{32'hF0, 32'hF0, 32'hF0, 32'hF0, 32'd5};
    logic [31:0] vb  [5] = '{32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'd5};
    logic [31:0] exp [5] = '{32'h0000_00F0, 32'h0000_00FF, 32'h0000_01EF, 32'hFFFF_FFF1, 32'h0};
    logic        ez  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], va[i], vb[i]);
      checks++;
      if (bus.done_o !== 1'b1) begin errors++; $display("FAIL op%0d_done got=%b exp=1", i, bus.done_o); end
      checks++;
      if (bus.data_o !== exp[i]) begin errors++; $display("FAIL op%0d_data got=%h exp=%h", i, bus.data_o, exp[i]); end
      checks++;
      if (bus.zero_o !== ez[i]) begin errors++; $display("FAIL op%0d_zero got=%b exp=%b", i, bus.zero_o, ez[i]); end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done_o !== 1'b0) begin errors++; $display("FAIL op%0d_done_pulse got=%b exp=0", i, bus.done_o); end
      checks++;
      if (bus.data_o !== exp[i]) begin errors++; $display("FAIL op%0d_hold got=%h exp=%h", i, bus.data_o, exp[i]); end
    end
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic ez);
    int cyc;
    int busy_cnt;
    cyc = 0;
    busy_cnt = 0;
    issue(ALUCTRL_MUL, a, b);
    if (bus.busy_o === 1'b1) busy_cnt++;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done_o === 1'b1) break;
      if (bus.busy_o === 1'b1) busy_cnt++;
    end
    checks++;
    if (cyc !== 32) begin errors++; $display("FAIL mul_latency a=%h got=%0d exp=32", a, cyc); end
    checks++;
    if (busy_cnt !== 32) begin errors++; $display("FAIL mul_busy_cycles a=%h got=%0d exp=32", a, busy_cnt); end
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL mul_busy_at_done got=%b exp=0", bus.busy_o); end
    checks++;
    if (bus.data_o !== exp) begin errors++; $display("FAIL mul_data got=%h exp=%h", bus.data_o, exp); end
    checks++;
    if (bus.zero_o !== ez) begin errors++; $display("FAIL mul_zero got=%b exp=%b", bus.zero_o, ez); end
  endtask

  task automatic test_reset_mid_mul();
    bit seen_done;
    issue(ALUCTRL_ADD, 32'd4, 32'd4);
    issue(ALUCTRL_MUL, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.data_o !== 32'h0 || bus.zero_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL midmul_reset got data=%h zero=%b busy=%b done=%b exp 0/1/0/0",
               bus.data_o, bus.zero_o, bus.busy_o, bus.done_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL midmul_no_done got=1 exp=0"); end
    issue(ALUCTRL_ADD, 32'd1, 32'd2);
    checks++;
    if (bus.done_o !== 1'b1 || bus.data_o !== 32'd3) begin
      errors++;
      $display("FAIL post_reset_add got done=%b data=%h exp 1/00000003", bus.done_o, bus.data_o);
    end
  endtask

  task automatic test_start_during_mul();
    int cyc;
    cyc = 0;
    issue(ALUCTRL_MUL, 32'd6, 32'd7);
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = ALUCTRL_ADD;
    bus.data1_i   = 32'd1;
    bus.data2_i   = 32'd2;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done_o === 1'b1) break;
    end
    checks++;
    if (cyc !== 32 || bus.data_o !== 32'd42) begin
      errors++;
      $display("FAIL mul_ignores_start got cyc=%0d data=%h exp 32/0000002a", cyc, bus.data_o);
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    checks++;
    if (bus.done_o !== 1'b1 || bus.data_o !== 32'd3) begin
      errors++;
      $display("FAIL add_after_mul got done=%b data=%h exp 1/00000003", bus.done_o, bus.data_o);
    end
  endtask

  task automatic test_wrap_reserved();
    issue(ALUCTRL_ADD, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (bus.done_o !== 1'b1 || bus.data_o !== 32'h0 || bus.zero_o !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap got done=%b data=%h zero=%b exp 1/00000000/1", bus.done_o, bus.data_o, bus.zero_o);
    end
    issue(ALUCTRL_ADD, 32'd1, 32'd2);
    issue(3'b111, 32'd5, 32'd3);
    checks++;
    if (bus.done_o !== 1'b1 || bus.data_o !== 32'h0 || bus.zero_o !== 1'b1) begin
      errors++;
      $display("FAIL reserved got done=%b data=%h zero=%b exp 1/00000000/1", bus.done_o, bus.data_o, bus.zero_o);
    end
  endtask

  task automatic test_back_to_back();
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = ALUCTRL_ADD;
    bus.data1_i   = 32'd1;
    bus.data2_i   = 32'd1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done_o !== 1'b1 || bus.data_o !== 32'd2) begin
      errors++;
      $display("FAIL b2b_first got done=%b data=%h exp 1/00000002", bus.done_o, bus.data_o);
    end
    bus.ALUCtrl_i = ALUCTRL_OR;
    bus.data1_i   = 32'd4;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done_o !== 1'b1 || bus.data_o !== 32'd5) begin
      errors++;
      $display("FAIL b2b_second got done=%b data=%h exp 1/00000005", bus.done_o, bus.data_o);
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done_o !== 1'b0 || bus.data_o !== 32'd5) begin
      errors++;
      $display("FAIL idle_hold got done=%b data=%h exp 0/00000005", bus.done_o, bus.data_o);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_logic_arith();
    test_mul(32'd6, 32'd7, 32'd42, 1'b0);
    test_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0);
    test_mul(32'h8000_0000, 32'd2, 32'h0, 1'b1);
    test_reset_mid_mul();
    test_start_during_mul();
    test_wrap_reserved();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
